// File: rtl/median_ctrl_sampler.sv
// median_ctrl_sampler: pops one control-token set from the four stage FIFOs (or injects defaults)
// and holds it for the next median stage, handshaking via control_sampled/filling.
module median_ctrl_sampler #(
   parameter int                       BUFF_SIZE_BIT = 16,
   parameter logic [BUFF_SIZE_BIT-1:0] BUFF_SIZE     = BUFF_SIZE_BIT'(1024),
   parameter logic [BUFF_SIZE_BIT-1:0] MEDIAN_POS    = BUFF_SIZE_BIT'(512),
   parameter logic [7:0]               DEFAULT_PIVOT = 8'd127,
   parameter bit                       FIRST_STAGE   = 1'b0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [7:0]               in_pivot,
   input  logic                     in_pivot_empty,
   output logic                     in_pivot_rd,
   input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
   input  logic                     in_buff_size_empty,
   output logic                     in_buff_size_rd,
   input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
   input  logic                     in_median_pos_empty,
   output logic                     in_median_pos_rd,
   input  logic [7:0]               in_second_median_value,
   input  logic                     in_second_median_value_empty,
   output logic                     in_second_median_value_rd,
   input  logic                     filling,
   output logic [7:0]               pivot_samp,
   output logic [BUFF_SIZE_BIT-1:0] buff_size_samp,
   output logic [BUFF_SIZE_BIT-1:0] median_pos_samp,
   output logic [7:0]               second_median_value_samp,
   output logic                     control_sampled,
   output logic [15:0]              set_count,
   output logic                     token_error
);
   typedef enum logic [1:0] {IDLE, HOLD, BUSY} state_t;
   state_t                   state_q, state_d;
   logic [7:0]               pivot_q, pivot_d, second_q, second_d, piv_n, sec_n;
   logic [BUFF_SIZE_BIT-1:0] bs_q, bs_d, mp_q, mp_d, bs_n, mp_n;
   logic [15:0]              cnt_q, cnt_d;
   logic                     err_q, err_d, avail, load, pop;
   always_comb begin
      avail   = ~(in_pivot_empty | in_buff_size_empty | in_median_pos_empty | in_second_median_value_empty);
      load    = (state_q == IDLE) && (FIRST_STAGE || avail);
      // the pop is gated by reset so a reset cycle never drains a FIFO word
      pop     = !FIRST_STAGE && !reset && (state_q == IDLE) && avail;
      piv_n   = FIRST_STAGE ? DEFAULT_PIVOT : in_pivot;
      bs_n    = FIRST_STAGE ? BUFF_SIZE : in_buff_size;
      mp_n    = FIRST_STAGE ? MEDIAN_POS : in_median_pos;
      sec_n   = FIRST_STAGE ? 8'd0 : in_second_median_value;
      state_d  = state_q;
      pivot_d  = pivot_q;
      bs_d     = bs_q;
      mp_d     = mp_q;
      second_d = second_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      case (state_q)
         IDLE: if (load) begin
            state_d  = HOLD;
            pivot_d  = piv_n;
            bs_d     = bs_n;
            mp_d     = mp_n;
            second_d = sec_n;
            cnt_d    = cnt_q + 16'd1;
            err_d    = err_q || (bs_n == '0) || (mp_n >= bs_n);
         end
         HOLD:    state_d = filling ? BUSY : HOLD;
         BUSY:    state_d = filling ? BUSY : IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         pivot_q  <= '0;
         bs_q     <= '0;
         mp_q     <= '0;
         second_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pivot_q  <= pivot_d;
         bs_q     <= bs_d;
         mp_q     <= mp_d;
         second_q <= second_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end
   assign in_pivot_rd               = pop;
   assign in_buff_size_rd           = pop;
   assign in_median_pos_rd          = pop;
   assign in_second_median_value_rd = pop;
   assign pivot_samp                = pivot_q;
   assign buff_size_samp            = bs_q;
   assign median_pos_samp           = mp_q;
   assign second_median_value_samp  = second_q;
   assign control_sampled           = (state_q == HOLD);
   assign set_count                 = cnt_q;
   assign token_error               = err_q;
endmodule

// File: tb/tb_median_ctrl_sampler.sv
// tb_median_ctrl_sampler: drives FWFT FIFO models into a normal and a first-stage sampler
// and compares held tokens, counters and handshake against a token-set reference queue.
module tb_median_ctrl_sampler;
   typedef struct {
      logic [7:0]  p;
      logic [15:0] b;
      logic [15:0] m;
      logic [7:0]  s;
   } set_t;
   logic        clock = 1'b0, reset = 1'b1, filling = 1'b0;
   logic [7:0]  in_pivot, in_second_median_value, pivot_samp, second_median_value_samp;
   logic [15:0] in_buff_size, in_median_pos, buff_size_samp, median_pos_samp, set_count;
   logic        in_pivot_empty, in_buff_size_empty, in_median_pos_empty, in_second_median_value_empty;
   logic        in_pivot_rd, in_buff_size_rd, in_median_pos_rd, in_second_median_value_rd;
   logic        control_sampled, token_error;
   logic [7:0]  f_piv, f_sec;
   logic [15:0] f_bs, f_mp, f_cnt;
   logic        f_prd, f_brd, f_mrd, f_srd, f_cs, f_err;
   logic [7:0]  qp[$], qs[$];
   logic [15:0] qb[$], qm[$];
   set_t        exp_q[$];
   set_t        m_last;
   logic [15:0] m_cnt;
   logic        m_err, partial, fs_rd, seen, got;
   logic [3:0]  last_rd;
   int          tests = 0, fails = 0;
   median_ctrl_sampler dut (
      .clock(clock), .reset(reset),
      .in_pivot(in_pivot), .in_pivot_empty(in_pivot_empty), .in_pivot_rd(in_pivot_rd),
      .in_buff_size(in_buff_size), .in_buff_size_empty(in_buff_size_empty), .in_buff_size_rd(in_buff_size_rd),
      .in_median_pos(in_median_pos), .in_median_pos_empty(in_median_pos_empty), .in_median_pos_rd(in_median_pos_rd),
      .in_second_median_value(in_second_median_value), .in_second_median_value_empty(in_second_median_value_empty),
      .in_second_median_value_rd(in_second_median_value_rd),
      .filling(filling), .pivot_samp(pivot_samp), .buff_size_samp(buff_size_samp),
      .median_pos_samp(median_pos_samp), .second_median_value_samp(second_median_value_samp),
      .control_sampled(control_sampled), .set_count(set_count), .token_error(token_error)
   );
   median_ctrl_sampler #(.FIRST_STAGE(1'b1)) dut_fs (
      .clock(clock), .reset(reset),
      .in_pivot(8'd0), .in_pivot_empty(1'b1), .in_pivot_rd(f_prd),
      .in_buff_size(16'd0), .in_buff_size_empty(1'b1), .in_buff_size_rd(f_brd),
      .in_median_pos(16'd0), .in_median_pos_empty(1'b1), .in_median_pos_rd(f_mrd),
      .in_second_median_value(8'd0), .in_second_median_value_empty(1'b1), .in_second_median_value_rd(f_srd),
      .filling(1'b0), .pivot_samp(f_piv), .buff_size_samp(f_bs),
      .median_pos_samp(f_mp), .second_median_value_samp(f_sec),
      .control_sampled(f_cs), .set_count(f_cnt), .token_error(f_err)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask
   task automatic refresh();
      in_pivot                     = qp.size() > 0 ? qp[0] : 8'd0;
      in_buff_size                 = qb.size() > 0 ? qb[0] : 16'd0;
      in_median_pos                = qm.size() > 0 ? qm[0] : 16'd0;
      in_second_median_value       = qs.size() > 0 ? qs[0] : 8'd0;
      in_pivot_empty               = qp.size() == 0;
      in_buff_size_empty           = qb.size() == 0;
      in_median_pos_empty          = qm.size() == 0;
      in_second_median_value_empty = qs.size() == 0;
   endtask
   task automatic push(input logic [7:0] p, input logic [15:0] b, input logic [15:0] m, input logic [7:0] s);
      set_t e;
      e.p = p; e.b = b; e.m = m; e.s = s;
      exp_q.push_back(e);
      qp.push_back(p); qb.push_back(b); qm.push_back(m); qs.push_back(s);
      refresh();
   endtask
   // one clock: sample pops mid-cycle, then retire popped FIFO words just after the edge
   task automatic cyc();
      #4;
      last_rd = {in_pivot_rd, in_buff_size_rd, in_median_pos_rd, in_second_median_value_rd};
      if (last_rd != 4'h0 && last_rd != 4'hF) partial = 1'b1;
      if (f_prd | f_brd | f_mrd | f_srd) fs_rd = 1'b1;
      @(posedge clock);
      #1;
      if (last_rd[3] && qp.size() > 0) qp.delete(0);
      if (last_rd[2] && qb.size() > 0) qb.delete(0);
      if (last_rd[1] && qm.size() > 0) qm.delete(0);
      if (last_rd[0] && qs.size() > 0) qs.delete(0);
      refresh();
   endtask
   task automatic wait_pop(input int budget);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         cyc();
         if (last_rd == 4'hF) got = 1'b1;
      end
      chk("pop_wait", got, 1);
   endtask
   task automatic samp_chk(input string tag);
      chk({tag, "_pivot"}, pivot_samp, m_last.p);
      chk({tag, "_bsize"}, buff_size_samp, m_last.b);
      chk({tag, "_mpos"}, median_pos_samp, m_last.m);
      chk({tag, "_second"}, second_median_value_samp, m_last.s);
   endtask
   task automatic check_set(input string tag);
      m_last = exp_q.pop_front();
      m_cnt++;
      if (m_last.b == 16'd0 || m_last.m >= m_last.b) m_err = 1'b1;
      samp_chk(tag);
      chk({tag, "_cs"}, control_sampled, 1);
      chk({tag, "_count"}, set_count, m_cnt);
      chk({tag, "_err"}, token_error, m_err);
   endtask
   task automatic release_set(input int n);
      filling = 1'b1;
      repeat (n) cyc();
      filling = 1'b0;
      cyc();
   endtask
   initial begin
      m_cnt = 0; m_err = 0; partial = 0; fs_rd = 0; last_rd = 0;
      m_last = '{p: 8'd0, b: 16'd0, m: 16'd0, s: 8'd0};
      refresh();
      @(posedge clock);
      #1;
      push(8'd60, 16'd300, 16'd150, 8'd0);
      seen = 1'b0;
      repeat (3) begin
         cyc();
         if (last_rd != 4'h0) seen = 1'b1;
      end
      chk("rst_no_pop", seen, 0);
      samp_chk("rst");
      chk("rst_cs", control_sampled, 0);
      chk("rst_count", set_count, 0);
      chk("rst_err", token_error, 0);
      chk("rst_fifo_kept", qp.size(), 1);
      reset = 1'b0;
      cyc();
      chk("t2_pop", last_rd, 4'hF);
      check_set("t2");
      chk("fs_pivot", f_piv, 127);
      chk("fs_bsize", f_bs, 1024);
      chk("fs_mpos", f_mp, 512);
      chk("fs_second", f_sec, 0);
      chk("fs_cs", f_cs, 1);
      chk("fs_count", f_cnt, 1);
      chk("fs_err", f_err, 0);
      push(8'd1, 16'd5, 16'd2, 8'd3);
      filling = 1'b1;
      cyc();
      chk("t2_cs_drop", control_sampled, 0);
      seen = 1'b0;
      repeat (4) begin
         cyc();
         if (last_rd != 4'h0) seen = 1'b1;
         samp_chk("t4_busy");
      end
      chk("t4_no_pop_busy", seen, 0);
      filling = 1'b0;
      cyc();
      chk("t4_gap_cycle", last_rd, 4'h0);
      samp_chk("t4_idle");
      wait_pop(1);
      check_set("t4");
      release_set(2);
      qp.push_back(8'd9); qb.push_back(16'd40); qs.push_back(8'd7);
      exp_q.push_back('{p: 8'd9, b: 16'd40, m: 16'd39, s: 8'd7});
      refresh();
      seen = 1'b0;
      repeat (10) begin
         cyc();
         if (last_rd != 4'h0) seen = 1'b1;
      end
      chk("t3_no_partial_wait", seen, 0);
      qm.push_back(16'd39);
      refresh();
      cyc();
      chk("t3_pop_together", last_rd, 4'hF);
      check_set("t3");
      release_set(1);
      push(8'd10, 16'd0, 16'd0, 8'd0);
      wait_pop(3);
      check_set("t5_bad");
      release_set(1);
      push(8'd20, 16'd100, 16'd50, 8'd5);
      wait_pop(3);
      check_set("t5_sticky");
      release_set(3);
      push(8'd33, 16'd64, 16'd32, 8'd1);
      wait_pop(3);
      check_set("t6_a");
      push(8'd44, 16'd80, 16'd79, 8'd2);
      reset = 1'b1;
      cyc();
      chk("t6_rst_no_pop", last_rd, 4'h0);
      m_last = '{p: 8'd0, b: 16'd0, m: 16'd0, s: 8'd0};
      m_cnt = 0; m_err = 0;
      samp_chk("t6_rst");
      chk("t6_rst_cs", control_sampled, 0);
      chk("t6_rst_count", set_count, 0);
      chk("t6_rst_err", token_error, 0);
      reset = 1'b0;
      wait_pop(2);
      check_set("t6_b");
      release_set(1);
      for (int k = 0; k < 12; k++) begin
         repeat ($urandom_range(0, 3)) cyc();
         push(8'($urandom), 16'($urandom_range(0, 20)), 16'($urandom_range(0, 20)), 8'($urandom));
         wait_pop(4);
         check_set("rnd");
         release_set($urandom_range(1, 4));
      end
      chk("no_partial_pop", partial, 0);
      chk("fs_never_rd", fs_rd, 0);
      chk("fs_final_count", f_cnt, 1);
      chk("fs_final_cs", f_cs, 1);
      chk("exp_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/median_ctrl_sampler.md
Name: median_ctrl_sampler

Overview:
- Reader side of the control-token FIFOs written by each median stage: pivot, buff_size, median_pos, second_median_value.
- Pops one complete token set atomically, holds it stable as the *_samp inputs of the next median stage, and handshakes with that stage via control_sampled/filling.
- With FIRST_STAGE=1 it reads no FIFOs and injects the default token set for the head of the pipeline.

Parameters:
BUFF_SIZE, 16'd1024, window size injected as buff_size in first-stage mode
MEDIAN_POS, 16'd512, median position injected in first-stage mode
DEFAULT_PIVOT, 8'd127, pivot injected in first-stage mode
BUFF_SIZE_BIT, 16, width of size/position tokens
FIRST_STAGE, 0, 1 = ignore FIFOs and inject defaults

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_pivot  in  8  pivot FIFO data (first-word fall-through)
in_pivot_empty  in  1  pivot FIFO empty
in_pivot_rd  out  1  pivot FIFO pop
in_buff_size  in  BUFF_SIZE_BIT  buff_size FIFO data
in_buff_size_empty  in  1  buff_size FIFO empty
in_buff_size_rd  out  1  buff_size FIFO pop
in_median_pos  in  BUFF_SIZE_BIT  median_pos FIFO data
in_median_pos_empty  in  1  median_pos FIFO empty
in_median_pos_rd  out  1  median_pos FIFO pop
in_second_median_value  in  8  second-median FIFO data
in_second_median_value_empty  in  1  second-median FIFO empty
in_second_median_value_rd  out  1  second-median FIFO pop
filling  in  1  downstream stage busy filling from current tokens
pivot_samp  out  8  held pivot
buff_size_samp  out  BUFF_SIZE_BIT  held buffer size
median_pos_samp  out  BUFF_SIZE_BIT  held median position
second_median_value_samp  out  8  held second median value
control_sampled  out  1  held token set is valid and unconsumed
set_count  out  16  number of token sets sampled since reset (wraps)
token_error  out  1  sticky: invalid token set sampled

Behaviour:
- Reset:
  - State goes to IDLE.
  - All *_rd, control_sampled and token_error are 0.
  - All *_samp are 0; set_count is 0.
- Reset mid-operation aborts any held set and performs no FIFO pop.
- FSM states: IDLE, HOLD, BUSY.
- IDLE, FIRST_STAGE=0:
  - When all four empty flags are 0, assert all four *_rd for exactly one cycle.
  - Capture all four data words on the same edge (FWFT), then go to HOLD.
  - If any FIFO is empty, pop nothing and stay in IDLE. Partial pops are forbidden.
- IDLE, FIRST_STAGE=1:
  - Load DEFAULT_PIVOT, BUFF_SIZE, MEDIAN_POS and 0 into the *_samp registers, then go to HOLD.
  - Never assert *_rd.
- Capture latency: *_samp and control_sampled are valid on the cycle after the pop/load edge.
- set_count increments on every capture.
- HOLD: control_sampled=1; wait for filling=1, then go to BUSY.
- BUSY: control_sampled=0; wait for filling=0, then go to IDLE.
  - The earliest next pop is in the IDLE cycle after filling falls (one idle cycle minimum).
- *_samp stay stable from capture until the next capture, including throughout BUSY and IDLE, because downstream next logic reads them after filling drops.
- If filling=1 already in the first HOLD cycle, go to BUSY on the next edge; control_sampled is high for exactly one cycle.
- If filling is never raised, HOLD persists indefinitely; there is no timeout.
- token_error is set, sticky until reset, when a captured set has buff_size==0 or median_pos>=buff_size (unsigned BUFF_SIZE_BIT compare). The set is still presented downstream.
- set_count wraps 16'hFFFF to 0.

Test Plan:
1. FIRST_STAGE=1, release reset, never toggle filling:
   - Cycle 2: pivot_samp=127, buff_size_samp=1024, median_pos_samp=512, second=0, control_sampled=1.
   - No *_rd asserted at any time.
2. FIRST_STAGE=0, all FIFOs preloaded with {60,300,150,0}:
   - Single-cycle rd on all four; next cycle samp={60,300,150,0}, control_sampled=1, set_count=1.
   - Drive filling=1 → control_sampled=0 next cycle.
3. Only in_median_pos FIFO empty for 10 cycles, then filled:
   - No rd during the wait; all four rd together the cycle after it goes non-empty.
4. Two sets queued, filling pulsed 1 for 5 cycles after the first capture:
   - Second pop occurs no earlier than 1 cycle after filling falls.
   - First set's samp values are unchanged throughout BUSY.
5. Token set {10,0,0,0}:
   - token_error=1 and remains 1 after a later valid set; cleared only by reset.
6. Assert reset during HOLD:
   - Outputs return to reset values next cycle; no extra pop.
   - The queued set is popped normally after reset is released.
